// File: rtl/ssdisp_pkg.sv
// ssdisp_pkg: shared types and glyph table for the 7-segment scan driver.
//   CODE_W  : width of a glyph code
//   digit_t : per-digit register contents {code, on, blink}
//   GLYPH   : 32-entry segment table, bit order {g,f,e,d,c,b,a}, 1 = lit
//   glyph() : segment pattern for a code, blanked when the digit is off
package ssdisp_pkg;

  localparam int CODE_W = 5;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              on;
    logic              blink;
  } digit_t;

  // 0x00-0x0F hex digits, 0x10-0x19 letters g,H,i,J,L,n,r,t,y,?, rest blank
  localparam logic [6:0] GLYPH [32] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71,
    7'h6F, 7'h76, 7'h10, 7'h1E, 7'h38, 7'h54, 7'h50, 7'h78,
    7'h6E, 7'h53, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
  };

  function automatic logic [6:0] glyph(input logic [CODE_W-1:0] code, input logic on);
    return on ? GLYPH[code] : 7'h00;
  endfunction

endpackage

// File: rtl/ssdisp_scan_if.sv
// ssdisp_scan_if: digit write bus from game control logic to the display driver.
//   wr_en    : write strobe, one digit per cycle
//   wr_addr  : digit index (AW bits)
//   wr_code  : glyph code
//   wr_on    : digit enable (0 = blank)
//   wr_blink : blink request (ignored unless SSDISP_SCAN_BLINK_EN is defined)
// master = game control side, slave = display driver side.
interface ssdisp_scan_if #(
  parameter int NDIG = 8
);
  localparam int AW = $clog2(NDIG);

  logic                          wr_en;
  logic [AW-1:0]                 wr_addr;
  logic [ssdisp_pkg::CODE_W-1:0] wr_code;
  logic                          wr_on;
  logic                          wr_blink;

  modport master (output wr_en, wr_addr, wr_code, wr_on, wr_blink);
  modport slave  (input  wr_en, wr_addr, wr_code, wr_on, wr_blink);

endinterface

// File: rtl/ssdisp_tick.sv
// ssdisp_tick: free-running modulo-DIV counter with a terminal-count flag.
//   hz100 : clock
//   reset : synchronous active-high reset, count returns to 0
//   tc    : high during the cycle the count sits at DIV-1 (wraps on that edge)
module ssdisp_tick #(
  parameter int DIV = 4
) (
  input  logic hz100,
  input  logic reset,
  output logic tc
);

  // DIV=1 still needs a one-bit register; it simply stays at 0 with tc stuck high
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  assign tc = (cnt == W'(DIV - 1));

  always_ff @(posedge hz100) begin
    if (reset)   cnt <= '0;
    else if (tc) cnt <= '0;
    else         cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/ssdisp_scan.sv
// ssdisp_scan: time-multiplexed driver for an NDIG-digit 7-segment display.
//   hz100 : clock (single domain)
//   reset : synchronous active-high reset
//   wr    : digit write bus (ssdisp_scan_if slave)
//   an    : registered one-hot digit select
//   seg   : registered segments {g,f,e,d,c,b,a}, 1 = lit
// Optional feature: define SSDISP_SCAN_BLINK_EN to add the blink counter,
// blink phase and the stored per-digit blink bit. Without it wr_blink is ignored.
module ssdisp_scan
  import ssdisp_pkg::*;
#(
  parameter int NDIG      = 8,
  parameter int SCAN_DIV  = 4,
  parameter int BLINK_DIV = 50
) (
  input  logic            hz100,
  input  logic            reset,
  ssdisp_scan_if.slave    wr,
  output logic [NDIG-1:0] an,
  output logic [6:0]      seg
);

  localparam int AW = $clog2(NDIG);

`ifdef SSDISP_SCAN_BLINK_EN
  typedef digit_t store_t;
`else
  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              on;
  } store_t;
`endif

  store_t        digits [NDIG];
  logic [AW-1:0] idx;
  logic          scan_tc;
  logic          addr_ok;
  logic [6:0]    seg_next;

  // one extra bit keeps the range check meaningful when NDIG is a power of two
  assign addr_ok = ({1'b0, wr.wr_addr} < (AW+1)'(NDIG));

  ssdisp_tick #(.DIV(SCAN_DIV)) u_scan_tick (
    .hz100 (hz100),
    .reset (reset),
    .tc    (scan_tc)
  );

`ifdef SSDISP_SCAN_BLINK_EN
  logic blink_tc;
  logic phase;

  ssdisp_tick #(.DIV(BLINK_DIV)) u_blink_tick (
    .hz100 (hz100),
    .reset (reset),
    .tc    (blink_tc)
  );

  always_ff @(posedge hz100) begin
    if (reset)         phase <= 1'b0;
    else if (blink_tc) phase <= ~phase;
  end
`endif

  // register file; writes are dropped while reset is high
  always_ff @(posedge hz100) begin
    if (reset) begin
      for (int i = 0; i < NDIG; i++) digits[i] <= '0;
    end else if (wr.wr_en && addr_ok) begin
      digits[wr.wr_addr].code  <= wr.wr_code;
      digits[wr.wr_addr].on    <= wr.wr_on;
`ifdef SSDISP_SCAN_BLINK_EN
      digits[wr.wr_addr].blink <= wr.wr_blink;
`endif
    end
  end

  // scan index advances only at the prescaler terminal count
  always_ff @(posedge hz100) begin
    if (reset) begin
      idx <= '0;
    end else if (scan_tc) begin
      if (idx == AW'(NDIG - 1)) idx <= '0;
      else                      idx <= idx + AW'(1);
    end
  end

  // pattern of the currently selected digit from the registers as they stand now
  always_comb begin
    seg_next = glyph(digits[idx].code, digits[idx].on);
`ifdef SSDISP_SCAN_BLINK_EN
    if (phase && digits[idx].blink) seg_next = 7'h00;
`endif
  end

  // output registers, one cycle behind the index and register file
  always_ff @(posedge hz100) begin
    if (reset) begin
      an  <= '0;
      seg <= '0;
    end else begin
      an  <= NDIG'(1) << idx;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_ssdisp_scan.sv
// tb_ssdisp_scan: directed, table-driven bench for ssdisp_scan with
// NDIG=4, SCAN_DIV=2, BLINK_DIV=4. Blink expectations follow whether
// SSDISP_SCAN_BLINK_EN is defined for the build.
module tb_ssdisp_scan;
  import ssdisp_pkg::*;

  localparam int NDIG      = 4;
  localparam int SCAN_DIV  = 2;
  localparam int BLINK_DIV = 4;

  // scan and blink periods are both 8 clocks, so digit 2 always lands in
  // blink phase 1 and digit 0 always in phase 0
`ifdef SSDISP_SCAN_BLINK_EN
  localparam logic [6:0] BLK = 7'h00;
`else
  localparam logic [6:0] BLK = 7'h77;
`endif

  logic            hz100 = 1'b0;
  logic            reset = 1'b1;
  logic [NDIG-1:0] an;
  logic [6:0]      seg;

  int errors = 0;
  int checks = 0;

  ssdisp_scan_if #(.NDIG(NDIG)) bus ();

  ssdisp_scan #(
    .NDIG      (NDIG),
    .SCAN_DIV  (SCAN_DIV),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .hz100 (hz100),
    .reset (reset),
    .wr    (bus.slave),
    .an    (an),
    .seg   (seg)
  );

  always #5 hz100 = ~hz100;

  typedef struct {
    logic       we;
    logic [1:0] addr;
    logic [4:0] code;
    logic       on;
    logic       blink;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic we, input logic [1:0] addr, input logic [4:0] code,
                        input logic on, input logic blink,
                        input logic [3:0] exp_an, input logic [6:0] exp_seg);
    vec_t v;
    v.we = we; v.addr = addr; v.code = code; v.on = on; v.blink = blink;
    v.exp_an = exp_an; v.exp_seg = exp_seg;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] addr, input logic [4:0] code,
                               input logic on, input logic blink);
    bus.wr_en    = we;
    bus.wr_addr  = addr;
    bus.wr_code  = code;
    bus.wr_on    = on;
    bus.wr_blink = blink;
  endtask

  task automatic checkOutput(input string tag, input int n,
                             input logic [3:0] exp_an, input logic [6:0] exp_seg);
    checks++;
    if (an !== exp_an) begin
      errors++;
      $display("[TB] FAIL %s[%0d] an: got %b want %b", tag, n, an, exp_an);
    end
    checks++;
    if (seg !== exp_seg) begin
      errors++;
      $display("[TB] FAIL %s[%0d] seg: got %b want %b", tag, n, seg, exp_seg);
    end
  endtask

  task automatic tick();
    @(posedge hz100);
    #1;
  endtask

  initial begin
    logic [3:0] post_an [9];
    post_an = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                4'b0100, 4'b1000, 4'b1000, 4'b0001};

    // edges 1..42 after reset release
    addVec(0, 0, 5'h00, 0, 0, 4'b0001, 7'h00); // e1
    addVec(0, 0, 5'h00, 0, 0, 4'b0001, 7'h00);
    addVec(0, 0, 5'h00, 0, 0, 4'b0010, 7'h00);
    addVec(0, 0, 5'h00, 0, 0, 4'b0010, 7'h00);
    addVec(0, 0, 5'h00, 0, 0, 4'b0100, 7'h00);
    addVec(0, 0, 5'h00, 0, 0, 4'b0100, 7'h00);
    addVec(0, 0, 5'h00, 0, 0, 4'b1000, 7'h00);
    addVec(0, 0, 5'h00, 0, 0, 4'b1000, 7'h00);
    addVec(1, 2, 5'h0A, 1, 0, 4'b0001, 7'h00); // e9 wrap, write digit2 'A'
    addVec(0, 0, 5'h00, 0, 0, 4'b0001, 7'h00);
    addVec(0, 0, 5'h00, 0, 0, 4'b0010, 7'h00);
    addVec(0, 0, 5'h00, 0, 0, 4'b0010, 7'h00);
    addVec(0, 0, 5'h00, 0, 0, 4'b0100, 7'h77); // e13
    addVec(0, 0, 5'h00, 0, 0, 4'b0100, 7'h77);
    addVec(0, 0, 5'h00, 0, 0, 4'b1000, 7'h00);
    addVec(1, 1, 5'h12, 1, 0, 4'b1000, 7'h00); // e16 write digit1 'i'
    addVec(0, 0, 5'h00, 0, 0, 4'b0001, 7'h00);
    addVec(0, 0, 5'h00, 0, 0, 4'b0001, 7'h00);
    addVec(1, 1, 5'h1C, 1, 0, 4'b0010, 7'h10); // e19 write to active digit
    addVec(0, 0, 5'h00, 0, 0, 4'b0010, 7'h00); // e20 new value one cycle later
    addVec(0, 0, 5'h00, 0, 0, 4'b0100, 7'h77);
    addVec(0, 0, 5'h00, 0, 0, 4'b0100, 7'h77);
    addVec(0, 0, 5'h00, 0, 0, 4'b1000, 7'h00);
    addVec(1, 1, 5'h0A, 0, 0, 4'b1000, 7'h00); // e24 digit1 'A' but off
    addVec(1, 0, 5'h19, 1, 0, 4'b0001, 7'h00); // e25 write active digit0 '?'
    addVec(0, 0, 5'h00, 0, 0, 4'b0001, 7'h53);
    addVec(0, 0, 5'h00, 0, 0, 4'b0010, 7'h00);
    addVec(0, 0, 5'h00, 0, 0, 4'b0010, 7'h00);
    addVec(0, 0, 5'h00, 0, 0, 4'b0100, 7'h77);
    addVec(0, 0, 5'h00, 0, 0, 4'b0100, 7'h77);
    addVec(0, 0, 5'h00, 0, 0, 4'b1000, 7'h00);
    addVec(0, 0, 5'h00, 0, 0, 4'b1000, 7'h00);
    addVec(1, 2, 5'h0A, 1, 1, 4'b0001, 7'h53); // e33 digit2 blink on
    addVec(1, 0, 5'h19, 1, 1, 4'b0001, 7'h53); // e34 digit0 blink on
    addVec(0, 0, 5'h00, 0, 0, 4'b0010, 7'h00);
    addVec(0, 0, 5'h00, 0, 0, 4'b0010, 7'h00);
    addVec(0, 0, 5'h00, 0, 0, 4'b0100, BLK);   // e37 phase 1
    addVec(0, 0, 5'h00, 0, 0, 4'b0100, BLK);
    addVec(0, 0, 5'h00, 0, 0, 4'b1000, 7'h00);
    addVec(0, 0, 5'h00, 0, 0, 4'b1000, 7'h00);
    addVec(0, 0, 5'h00, 0, 0, 4'b0001, 7'h53); // e41 phase 0, digit0 shown
    addVec(0, 0, 5'h00, 0, 0, 4'b0001, 7'h53);

    // reset held for three edges
    applyStimulus(0, 0, 5'h00, 0, 0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("reset", i, 4'b0000, 7'h00);
    end
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].code, vecs[i].on, vecs[i].blink);
      tick();
      checkOutput("scan", i + 1, vecs[i].exp_an, vecs[i].exp_seg);
    end
    applyStimulus(0, 0, 5'h00, 0, 0);

    // run on until digit2 is active (edges 43..45)
    tick(); checkOutput("pre", 43, 4'b0010, 7'h00);
    tick(); checkOutput("pre", 44, 4'b0010, 7'h00);
    tick(); checkOutput("pre", 45, 4'b0100, BLK);

    // reset mid-scan, with writes attempted while reset is high
    reset = 1'b1;
    applyStimulus(1, 3, 5'h08, 1, 0);
    tick(); checkOutput("midrst", 0, 4'b0000, 7'h00);
    applyStimulus(1, 1, 5'h08, 1, 1);
    tick(); checkOutput("midrst", 1, 4'b0000, 7'h00);

    // release with a write held inhibited; every slot must stay blank
    reset = 1'b0;
    applyStimulus(0, 0, 5'h08, 1, 0);
    for (int k = 0; k < 9; k++) begin
      tick();
      checkOutput("post", k + 1, post_an[k], 7'h00);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
